// File: rtl/vga_sync_decoder_pkg.sv
`default_nettype none
// ============================================================================
// vga_sync_decoder_pkg : 640x480@60 timing defaults and decoder FSM states
// Rev 1.0
// ============================================================================
package vga_sync_decoder_pkg;

    localparam int C_H_TOTAL      = 800;
    localparam int C_V_TOTAL      = 525;
    localparam int C_HSYNC_START  = 656;
    localparam int C_HSYNC_PULSE  = 96;
    localparam int C_HSYNC_END    = C_HSYNC_START + C_HSYNC_PULSE;
    localparam int C_VSYNC_START  = 490;
    localparam int C_VSYNC_PULSE  = 2;
    localparam int C_VSYNC_END    = C_VSYNC_START + C_VSYNC_PULSE;
    localparam int C_SCREEN_H_RES = 640;
    localparam int C_SCREEN_V_RES = 480;
    localparam int C_LOCK_FRAMES  = 2;
    localparam int C_X_POS_W      = 10;
    localparam int C_Y_POS_W      = 10;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        H_ALIGN = 2'd1,
        V_ALIGN = 2'd2,
        LOCKED  = 2'd3
    } sync_dec_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_sync_decoder_sync_edge_det.sv
`default_nettype none
// ============================================================================
// sync_edge_det : previous-sample register with rise/fall strobes, px_en gated
// Rev 1.0
// ============================================================================
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic px_en_i,
    input  logic sync_i,
    output logic rise_o,
    output logic fall_o
);

    logic prev_q;

    // Idle level of an active-low sync is high, so reset to 1 avoids a spurious fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b1;
        end else if (px_en_i) begin
            prev_q <= sync_i;
        end
    end

    assign fall_o = px_en_i &  prev_q & ~sync_i;
    assign rise_o = px_en_i & ~prev_q &  sync_i;

endmodule
`default_nettype wire

// File: rtl/vga_sync_decoder.sv
`default_nettype none
// ============================================================================
// vga_sync_decoder : recovers pixel x/y, lock and timing errors from VGA syncs
// Rev 1.0
// ============================================================================
module vga_sync_decoder
    import vga_sync_decoder_pkg::*;
#(
    parameter int H_TOTAL      = C_H_TOTAL,
    parameter int V_TOTAL      = C_V_TOTAL,
    parameter int HSYNC_START  = C_HSYNC_START,
    parameter int HSYNC_PULSE  = C_HSYNC_PULSE,
    parameter int VSYNC_START  = C_VSYNC_START,
    parameter int VSYNC_PULSE  = C_VSYNC_PULSE,
    parameter int SCREEN_H_RES = C_SCREEN_H_RES,
    parameter int SCREEN_V_RES = C_SCREEN_V_RES,
    parameter int LOCK_FRAMES  = C_LOCK_FRAMES,
    parameter int X_POS_W      = C_X_POS_W,
    parameter int Y_POS_W      = C_Y_POS_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               px_en_i,
    input  logic               hsync_i,
    input  logic               vsync_i,
    output logic [X_POS_W-1:0] x_pos_o,
    output logic [Y_POS_W-1:0] y_pos_o,
    output logic               visible_o,
    output logic               locked_o,
    output logic               frame_start_o,
    output logic               h_err_o,
    output logic               v_err_o
);

    localparam int FCNT_W = $clog2(LOCK_FRAMES + 1);

    localparam logic [X_POS_W-1:0] C_X_LAST     = X_POS_W'(H_TOTAL - 1);
    localparam logic [X_POS_W-1:0] C_X_FALL     = X_POS_W'(HSYNC_START);
    localparam logic [X_POS_W-1:0] C_X_PRE_FALL = X_POS_W'(HSYNC_START - 1);
    localparam logic [X_POS_W-1:0] C_X_PRE_RISE = X_POS_W'(HSYNC_START + HSYNC_PULSE - 1);
    localparam logic [X_POS_W-1:0] C_X_H_RES    = X_POS_W'(SCREEN_H_RES);
    localparam logic [Y_POS_W-1:0] C_Y_LAST     = Y_POS_W'(V_TOTAL - 1);
    localparam logic [Y_POS_W-1:0] C_Y_FALL     = Y_POS_W'(VSYNC_START);
    localparam logic [Y_POS_W-1:0] C_Y_PRE_FALL = Y_POS_W'(VSYNC_START - 1);
    localparam logic [Y_POS_W-1:0] C_Y_PRE_RISE = Y_POS_W'(VSYNC_START + VSYNC_PULSE - 1);
    localparam logic [Y_POS_W-1:0] C_Y_V_RES    = Y_POS_W'(SCREEN_V_RES);
    localparam logic [FCNT_W-1:0]  C_FCNT_LAST  = FCNT_W'(LOCK_FRAMES - 1);

    sync_dec_state_t      state_q, state_d;
    logic [X_POS_W-1:0]   x_q, x_d;
    logic [Y_POS_W-1:0]   y_q, y_d;
    logic                 hcnt_q, hcnt_d;
    logic [FCNT_W-1:0]    fcnt_q, fcnt_d;
    logic                 vseen_q, vseen_d;
    logic                 vis_q, vis_d;
    logic                 locked_q, locked_d;
    logic                 fs_q, fs_d;
    logic                 herr_q, herr_d;
    logic                 verr_q, verr_d;

    logic hs_rise, hs_fall, vs_rise, vs_fall;
    logic x_last, line_wrap;

    sync_edge_det u_hs_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .px_en_i (px_en_i),
        .sync_i  (hsync_i),
        .rise_o  (hs_rise),
        .fall_o  (hs_fall)
    );

    sync_edge_det u_vs_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .px_en_i (px_en_i),
        .sync_i  (vsync_i),
        .rise_o  (vs_rise),
        .fall_o  (vs_fall)
    );

    assign x_last    = (x_q == C_X_LAST);
    // An hsync fall reloads x, so it suppresses the line wrap even at x_last.
    assign line_wrap = x_last & ~hs_fall;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        hcnt_d   = hcnt_q;
        fcnt_d   = fcnt_q;
        vseen_d  = vseen_q;
        vis_d    = vis_q;
        locked_d = locked_q;
        fs_d     = 1'b0;
        herr_d   = 1'b0;
        verr_d   = 1'b0;

        if (px_en_i) begin
            if (hs_fall) begin
                x_d    = C_X_FALL;
                herr_d = (state_q != SEARCH) && (x_q != C_X_PRE_FALL);
            end else if (x_last) begin
                x_d = '0;
            end else begin
                x_d = x_q + 1'b1;
            end
            if (hs_rise && (x_q != C_X_PRE_RISE)) begin
                herr_d = 1'b1;
            end

            if (vs_fall) begin
                y_d     = C_Y_FALL;
                vseen_d = 1'b1;
                verr_d  = ((state_q == LOCKED) || ((state_q == V_ALIGN) && vseen_q))
                          && !(line_wrap && (y_q == C_Y_PRE_FALL));
            end else if (line_wrap) begin
                if (y_q == C_Y_LAST) begin
                    y_d  = '0;
                    fs_d = 1'b1;
                end else begin
                    y_d = y_q + 1'b1;
                end
            end
            if (vs_rise && !(line_wrap && (y_q == C_Y_PRE_RISE))) begin
                verr_d = 1'b1;
            end

            // hcnt_q marks one good hsync fall already seen in H_ALIGN.
            case (state_q)
                SEARCH: begin
                    if (hs_fall) begin
                        state_d = H_ALIGN;
                        hcnt_d  = 1'b0;
                    end
                end
                H_ALIGN: begin
                    if (herr_d) begin
                        hcnt_d = 1'b0;
                    end else if (hs_fall) begin
                        if (hcnt_q) begin
                            state_d = V_ALIGN;
                            fcnt_d  = '0;
                        end
                        hcnt_d = ~hcnt_q;
                    end
                end
                V_ALIGN: begin
                    if (herr_d) begin
                        state_d = H_ALIGN;
                        hcnt_d  = 1'b0;
                        fcnt_d  = '0;
                    end else if (verr_d) begin
                        fcnt_d = '0;
                    end else if (vs_fall && vseen_q) begin
                        if (fcnt_q == C_FCNT_LAST) begin
                            state_d = LOCKED;
                            fcnt_d  = '0;
                        end else begin
                            fcnt_d = fcnt_q + 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (herr_d) begin
                        state_d = H_ALIGN;
                        hcnt_d  = 1'b0;
                        fcnt_d  = '0;
                    end else if (verr_d) begin
                        state_d = V_ALIGN;
                        fcnt_d  = '0;
                    end
                end
                default: state_d = SEARCH;
            endcase

            locked_d = (state_d == LOCKED);
            vis_d    = locked_d && (x_d < C_X_H_RES) && (y_d < C_Y_V_RES);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= SEARCH;
            x_q      <= '0;
            y_q      <= '0;
            hcnt_q   <= 1'b0;
            fcnt_q   <= '0;
            vseen_q  <= 1'b0;
            vis_q    <= 1'b0;
            locked_q <= 1'b0;
            fs_q     <= 1'b0;
            herr_q   <= 1'b0;
            verr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            hcnt_q   <= hcnt_d;
            fcnt_q   <= fcnt_d;
            vseen_q  <= vseen_d;
            vis_q    <= vis_d;
            locked_q <= locked_d;
            fs_q     <= fs_d;
            herr_q   <= herr_d;
            verr_q   <= verr_d;
        end
    end

    assign x_pos_o       = x_q;
    assign y_pos_o       = y_q;
    assign visible_o     = vis_q;
    assign locked_o      = locked_q;
    assign frame_start_o = fs_q;
    assign h_err_o       = herr_q;
    assign v_err_o       = verr_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_vga_sync_decoder : directed bench on a scaled-down raster (20x12 ticks)
// Rev 1.0
// ============================================================================
module tb_vga_sync_decoder;

    localparam int H_TOTAL  = 20;
    localparam int H_RES    = 12;
    localparam int HS_START = 14;
    localparam int HS_PULSE = 3;
    localparam int V_TOTAL  = 12;
    localparam int V_RES    = 8;
    localparam int VS_START = 9;
    localparam int VS_PULSE = 2;
    localparam int XW       = 5;
    localparam int YW       = 4;
    localparam int FRAME    = H_TOTAL * V_TOTAL;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          px_en = 1'b0;
    logic          hsync = 1'b1;
    logic          vsync = 1'b1;
    logic [XW-1:0] x_pos;
    logic [YW-1:0] y_pos;
    logic          visible, locked, frame_start, h_err, v_err;

    int n_vec = 0;
    int n_err = 0;

    int gx = 0;
    int gy = 0;
    bit short_pending = 0, wide_pending = 0, drop_pending = 0;
    bit short_now = 0, wide_now = 0;

    int n_herr, n_verr, n_fs, n_lock_ticks, n_track;
    int herr_x, herr_y, verr_x, verr_y, fs_x, fs_y;
    string track_msg;

    vga_sync_decoder #(
        .H_TOTAL      (H_TOTAL),
        .V_TOTAL      (V_TOTAL),
        .HSYNC_START  (HS_START),
        .HSYNC_PULSE  (HS_PULSE),
        .VSYNC_START  (VS_START),
        .VSYNC_PULSE  (VS_PULSE),
        .SCREEN_H_RES (H_RES),
        .SCREEN_V_RES (V_RES),
        .LOCK_FRAMES  (2),
        .X_POS_W      (XW),
        .Y_POS_W      (YW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .px_en_i       (px_en),
        .hsync_i       (hsync),
        .vsync_i       (vsync),
        .x_pos_o       (x_pos),
        .y_pos_o       (y_pos),
        .visible_o     (visible),
        .locked_o      (locked),
        .frame_start_o (frame_start),
        .h_err_o       (h_err),
        .v_err_o       (v_err)
    );

    always #5 clk = ~clk;

    task automatic clear_stats();
        n_herr = 0; n_verr = 0; n_fs = 0; n_lock_ticks = 0; n_track = 0;
        herr_x = -1; herr_y = -1; verr_x = -1; verr_y = -1; fs_x = -1; fs_y = -1;
        track_msg = "";
    endtask

    // One generator pixel: px_en high for one clk, low for the next.
    task automatic tick(input bit track);
        bit hs, vs, ev;
        int ex, ey;
        if (gx == 0) begin
            short_now = short_pending; wide_now = wide_pending;
            short_pending = 0; wide_pending = 0;
        end
        hs = !(gx >= HS_START && gx < HS_START + HS_PULSE + (wide_now ? 1 : 0));
        vs = !(gy >= VS_START && gy < VS_START + VS_PULSE);
        @(negedge clk);
        px_en = 1'b1; hsync = hs; vsync = vs;
        @(negedge clk);
        px_en = 1'b0;
        ex = gx; ey = gy;
        ev = (ex < H_RES) && (ey < V_RES);
        if (h_err)       begin n_herr++; herr_x = ex; herr_y = ey; end
        if (v_err)       begin n_verr++; verr_x = ex; verr_y = ey; end
        if (frame_start) begin n_fs++;   fs_x = ex;   fs_y = ey;   end
        if (locked) n_lock_ticks++;
        if (track && ((locked && (int'(x_pos) != ex || int'(y_pos) != ey || visible !== ev))
                      || (!locked && visible !== 1'b0))) begin
            if (n_track == 0)
                track_msg = $sformatf("gen(%0d,%0d) got x=%0d y=%0d vis=%0b lock=%0b",
                                      ex, ey, x_pos, y_pos, visible, locked);
            n_track++;
        end
        gx++;
        if (gx == (short_now ? H_TOTAL - 1 : H_TOTAL)) begin
            gx = 0;
            gy++;
            if (drop_pending) begin gy++; drop_pending = 0; end
            if (gy >= V_TOTAL) gy -= V_TOTAL;
        end
    endtask

    task automatic run_to(input int tx, input int ty, input bit track);
        int guard = 0;
        while (!(gx == tx && gy == ty) && guard < 3 * FRAME) begin
            tick(track);
            guard++;
        end
        if (!(gx == tx && gy == ty)) begin
            n_vec++; n_err++;
            $display("FAIL run_to: generator at (%0d,%0d), required (%0d,%0d)", gx, gy, tx, ty);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_vec++; if (x_pos !== '0) begin n_err++; $display("FAIL reset_x: got %0d, exp 0", x_pos); end
        n_vec++; if (y_pos !== '0) begin n_err++; $display("FAIL reset_y: got %0d, exp 0", y_pos); end
        n_vec++;
        if ({visible, locked, frame_start, h_err, v_err} !== 5'b0) begin
            n_err++; $display("FAIL reset_flags: got %b, exp 00000", {visible, locked, frame_start, h_err, v_err});
        end
        rst_n = 1'b1;
    endtask

    // From a fresh reset the lock lands on the vsync fall of the third frame.
    task automatic test_lock();
        clear_stats();
        repeat (2 * FRAME + VS_START * H_TOTAL) tick(1);
        n_vec++; if (n_lock_ticks != 0) begin n_err++; $display("FAIL early_lock: locked ticks %0d, exp 0", n_lock_ticks); end
        n_vec++; if (n_herr + n_verr != 0) begin n_err++; $display("FAIL startup_err: h=%0d v=%0d, exp 0", n_herr, n_verr); end
        n_vec++; if (n_fs != 2) begin n_err++; $display("FAIL startup_fs: got %0d, exp 2", n_fs); end
        tick(1);
        n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL lock: got %0b, exp 1", locked); end
        n_vec++; if (n_track != 0) begin n_err++; $display("FAIL lock_track: %0d bad, first %s", n_track, track_msg); end
    endtask

    task automatic test_frame_start();
        clear_stats();
        repeat (2 * FRAME) tick(1);
        n_vec++; if (n_fs != 2) begin n_err++; $display("FAIL fs_count: got %0d, exp 2", n_fs); end
        n_vec++; if (fs_x != 0 || fs_y != 0) begin n_err++; $display("FAIL fs_pos: got (%0d,%0d), exp (0,0)", fs_x, fs_y); end
        n_vec++; if (n_track != 0) begin n_err++; $display("FAIL track: %0d bad, first %s", n_track, track_msg); end
        n_vec++; if (n_lock_ticks != 2 * FRAME) begin n_err++; $display("FAIL hold_lock: got %0d, exp %0d", n_lock_ticks, 2 * FRAME); end
        n_vec++; if (n_herr + n_verr != 0) begin n_err++; $display("FAIL clean_err: h=%0d v=%0d, exp 0", n_herr, n_verr); end
    endtask

    task automatic test_stall();
        logic [XW+YW+4:0] snap;
        int bad = 0;
        run_to(5, 4, 1);
        snap = {x_pos, y_pos, visible, locked, frame_start, h_err, v_err};
        n_vec++; if (int'(x_pos) != 4 || locked !== 1'b1) begin n_err++; $display("FAIL pre_stall: x=%0d lock=%0b, exp x=4 lock=1", x_pos, locked); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            hsync = i[0]; vsync = ~i[0];
            if ({x_pos, y_pos, visible, locked, frame_start, h_err, v_err} !== snap) bad++;
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL stall_hold: %0d changed clks, exp 0", bad); end
        clear_stats();
        repeat (30) tick(1);
        n_vec++; if (n_track != 0 || n_herr + n_verr != 0 || n_lock_ticks != 30) begin
            n_err++; $display("FAIL post_stall: track=%0d h=%0d v=%0d lockticks=%0d, exp 0 0 0 30", n_track, n_herr, n_verr, n_lock_ticks);
        end
    endtask

    task automatic relock_two_falls(input string name);
        run_to(0, VS_START, 1);
        tick(1);
        n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL %s_first_fall: lock=%0b, exp 0", name, locked); end
        run_to(0, VS_START, 1);
        tick(1);
        n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL %s_relock: lock=%0b, exp 1", name, locked); end
    endtask

    task automatic test_short_line();
        run_to(0, 3, 1);
        short_pending = 1;
        clear_stats();
        repeat ((H_TOTAL - 1) + HS_START + 1) tick(0);
        n_vec++; if (n_herr != 1 || herr_x != HS_START || herr_y != 4) begin
            n_err++; $display("FAIL short_line_herr: n=%0d at (%0d,%0d), exp 1 at (%0d,4)", n_herr, herr_x, herr_y, HS_START);
        end
        n_vec++; if (locked !== 1'b0 || n_verr != 0) begin n_err++; $display("FAIL short_line_unlock: lock=%0b verr=%0d, exp 0 0", locked, n_verr); end
        relock_two_falls("short_line");
    endtask

    task automatic test_bad_hsync_width();
        run_to(0, 2, 1);
        wide_pending = 1;
        clear_stats();
        repeat (H_TOTAL) tick(0);
        n_vec++; if (n_herr != 1 || herr_x != HS_START + HS_PULSE + 1 || herr_y != 2) begin
            n_err++; $display("FAIL wide_hs_herr: n=%0d at (%0d,%0d), exp 1 at (%0d,2)", n_herr, herr_x, herr_y, HS_START + HS_PULSE + 1);
        end
        n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL wide_hs_unlock: lock=%0b, exp 0", locked); end
        relock_two_falls("wide_hs");
    endtask

    task automatic test_short_frame();
        run_to(0, 3, 1);
        drop_pending = 1;
        clear_stats();
        run_to(0, VS_START, 0);
        tick(0);
        n_vec++; if (n_verr != 1 || verr_x != 0 || verr_y != VS_START) begin
            n_err++; $display("FAIL short_frame_verr: n=%0d at (%0d,%0d), exp 1 at (0,%0d)", n_verr, verr_x, verr_y, VS_START);
        end
        n_vec++; if (locked !== 1'b0 || n_herr != 0) begin n_err++; $display("FAIL short_frame_unlock: lock=%0b herr=%0d, exp 0 0", locked, n_herr); end
        relock_two_falls("short_frame");
    endtask

    task automatic test_reset_mid_frame();
        run_to(6, 4, 1);
        n_vec++; if (locked !== 1'b1 || int'(x_pos) != 5) begin n_err++; $display("FAIL pre_reset: lock=%0b x=%0d, exp 1 5", locked, x_pos); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({x_pos, y_pos, visible, locked, frame_start, h_err, v_err} !== '0) begin
            n_err++; $display("FAIL mid_reset: x=%0d y=%0d flags=%b, exp all 0", x_pos, y_pos, {visible, locked, frame_start, h_err, v_err});
        end
        repeat (2) @(negedge clk);
        gx = 0; gy = 0;
        short_pending = 0; wide_pending = 0; drop_pending = 0;
        hsync = 1'b1; vsync = 1'b1;
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_lock();
        test_frame_start();
        test_stall();
        test_short_line();
        test_bad_hsync_width();
        test_short_frame();
        test_reset_mid_frame();
        test_lock();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Recovers pixel coordinates and a lock indication from a 640x480@60 VGA hsync/vsync pair. It is the receive-side counterpart of the VGA timing generator. It sits on the board clock, gated by the same pixel-enable strobe, so a testbench or loopback checker can decode what the generator drives. It also measures line and frame length and flags deviations from the standard timing.

## Interface
- `H_TOTAL`, 800: pixel ticks per line.
- `V_TOTAL`, 525: lines per frame.
- `HSYNC_START`, 656: generator x at which hsync asserts.
- `HSYNC_PULSE`, 96: hsync low width in ticks.
- `VSYNC_START`, 490: generator y at which vsync asserts.
- `VSYNC_PULSE`, 2: vsync low width in lines.
- `SCREEN_H_RES`, 640; `SCREEN_V_RES`, 480: visible area.
- `LOCK_FRAMES`, 2: consecutive good frames required to lock.
- `clk`, in, 1: board clock; single clock domain.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `px_en_i`, in, 1: pixel tick strobe; all sampling and counting happens only on cycles with `px_en_i`=1.
- `hsync_i`, in, 1: horizontal sync, active-low.
- `vsync_i`, in, 1: vertical sync, active-low.
- `x_pos_o`, out, X_POS_W: reconstructed generator x.
- `y_pos_o`, out, Y_POS_W: reconstructed generator y.
- `visible_o`, out, 1: locked and x<640 and y<480.
- `locked_o`, out, 1: state is LOCKED.
- `frame_start_o`, out, 1: one-clk pulse when y wraps to 0.
- `h_err_o`, out, 1: one-clk pulse on a bad line length or bad hsync width.
- `v_err_o`, out, 1: one-clk pulse on a bad frame length or bad vsync width.

## Operation
- **Sync sampling:** on each px_en tick, `hsync_i` and `vsync_i` are compared with the registered previous samples `hs_q` and `vs_q` (reset 1). A falling edge is prev=1, cur=0; a rising edge is prev=0, cur=1.
- **Horizontal, hsync fall:**
  - `x` is set to HSYNC_START.
  - If state is not SEARCH and the pre-load `x` is not HSYNC_START-1 (line length ≠ H_TOTAL), `h_err_o` pulses.
- **Horizontal, otherwise:** `x` increments and wraps H_TOTAL-1 → 0.
- **Horizontal, hsync rise:** if `x` is not HSYNC_START+HSYNC_PULSE-1, `h_err_o` pulses.
- **Vertical, line wrap:** `y` increments on every `x` wrap, and wraps V_TOTAL-1 → 0.
  - `frame_start_o` pulses on the 524 → 0 transition.
- **Vertical, vsync fall:**
  - `y` is forced to VSYNC_START. The generator changes vsync at x=0, so the wrap and the fall coincide on the same tick; the force wins.
  - If state is LOCKED or V_ALIGN with a prior vsync fall seen, and the pre-load `y` is not VSYNC_START-1 with `x` at wrap, `v_err_o` pulses.
- **Vertical, vsync rise:** must occur at a wrap to y=VSYNC_START+VSYNC_PULSE; otherwise `v_err_o` pulses.
- **FSM:**
  - SEARCH → H_ALIGN on the first hsync fall.
  - H_ALIGN → V_ALIGN after 2 consecutive hsync falls without `h_err`.
  - V_ALIGN → LOCKED after LOCK_FRAMES consecutive good frames, each delimited by vsync falls; the good-frame counter runs in V_ALIGN.
  - Any `h_err` in V_ALIGN or LOCKED → H_ALIGN, and the good-frame counter clears.
  - `v_err` in LOCKED → V_ALIGN.
  - Errors in SEARCH or H_ALIGN set no state change beyond H_ALIGN's line counter reset.
- **Simultaneous events:** an hsync error and a vsync error on one tick both pulse; the FSM takes the H_ALIGN transition.

## Timing
- **Reset values:** `x_pos_o`=0, `y_pos_o`=0, all 1-bit outputs 0, state SEARCH, `hs_q`=`vs_q`=1, frame counter 0.
- **Latency:** outputs are registered and update in the clk cycle after the px_en tick that sampled the syncs. `x_pos_o`/`y_pos_o` then equal the generator coordinates of the sampled pixel.
- **Hold between ticks:** with `px_en_i`=0 all state and outputs hold; pulses last exactly one clk.
- **`locked_o`** rises on the clk after the qualifying vsync fall tick.
- **Reset mid-frame:** immediate return to reset values; relock requires the full sequence again.

## Structure
- `config_pkg` additions:
  - typedef enum `sync_dec_state_t` {SEARCH, H_ALIGN, V_ALIGN, LOCKED}.
  - `LOCK_FRAMES`.
- Reused from `config_pkg`: HSYNC_START/END, VSYNC_START/END, H_TOTAL, V_TOTAL, X_POS_W, Y_POS_W.
- Sub-module `sync_edge_det`: registered prev sample plus rise/fall outputs, qualified by `px_en`. Instantiated twice, once for hsync and once for vsync.

## Test plan
- **Lock:** drive the real generator from reset → `locked_o`=1 after 2 full frames plus a partial frame. Once locked, on each px_en tick `x_pos_o`/`y_pos_o` equal the generator x/y, and `visible_o` matches x<640 && y<480.
- **Frame start:** once locked → `frame_start_o` pulses exactly once per 420000 ticks, on y 524 → 0.
- **Short line:** shorten one line to 799 ticks → one `h_err_o` pulse at the next hsync fall, state goes to H_ALIGN, `locked_o`=0, and the decoder relocks 2 frames later.
- **Bad hsync width:** stretch hsync to 97 ticks → `h_err_o` at the rise.
- **Short frame:** drop one line (524-line frame) → `v_err_o` at the vsync fall, state goes to V_ALIGN, and relock after LOCK_FRAMES good frames.
- **px_en stall and reset:**
  - Hold `px_en_i`=0 for 10 clks mid-line → no output change.
  - Assert `rst_n`=0 mid-frame → all outputs 0 within the same cycle.
